// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit.
// Optional build macro: LSU_MISALIGN_CHECK_EN (see load_store_unit.sv).
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned TIMEOUT_DEF = 16;

  function automatic logic f3_bad(
    input logic       we,
    input logic [2:0] f3
  );
    if (we) return f3 > F3_W;
    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

endpackage

// File: rtl/load_store_unit_ld_format.sv
// Load data formatter: lane select plus sign/zero extension.
// Combinational; lanes past the word boundary read as zero.
module ld_format
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] result
);

  logic [15:0] sh;

  assign sh = 16'(rdata >> {addr_lo, 3'b000});

  always_comb begin
    result = rdata;
    unique case (1'b1)
      (funct3 == F3_B):  result = {{24{sh[7]}}, sh[7:0]};
      (funct3 == F3_H):  result = {{16{sh[15]}}, sh};
      (funct3 == F3_BU): result = {24'h0, sh[7:0]};
      (funct3 == F3_HU): result = {16'h0, sh};
      default:           result = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: single outstanding request, timeout abort.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned half/word accesses.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ld_data_f,
  output logic        done,
  output logic        err,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e  state;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic [CW-1:0] cnt;
  logic        hit;
  logic        bad_n;
  logic [3:0]  strb_n;
  logic [31:0] wd_n;
  logic [31:0] fmt;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign hit       = (cnt == CW'(TIMEOUT_CYCLES - 1));

  ld_format u_ld_format (
    .rdata   (mem_rdata),
    .funct3  (f3_q),
    .addr_lo (off_q),
    .result  (fmt)
  );

  always_comb begin
    bad_n = f3_bad(req_we, req_funct3);
`ifdef LSU_MISALIGN_CHECK_EN
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      bad_n = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
      bad_n = 1'b1;
`endif
  end

  // Lanes shifted past byte 3 fall off: misaligned access truncates.
  always_comb begin
    strb_n = 4'b1111;
    wd_n   = req_wdata;
    unique case (1'b1)
      (req_funct3[1:0] == 2'b00): begin
        strb_n = 4'b0001 << req_addr[1:0];
        wd_n   = {4{req_wdata[7:0]}};
      end
      (req_funct3[1:0] == 2'b01): begin
        strb_n = 4'b0011 << req_addr[1:0];
        wd_n   = {2{req_wdata[15:0]}};
      end
      default: begin
        strb_n = 4'b1111;
        wd_n   = req_wdata;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      we_q      <= 1'b0;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wstrb <= 4'h0;
      mem_wdata <= 32'h0;
      ld_data_f <= 32'h0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            f3_q      <= req_funct3;
            off_q     <= req_addr[1:0];
            we_q      <= req_we;
            cnt       <= '0;
            mem_we    <= req_we;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wstrb <= strb_n;
            mem_wdata <= wd_n;
            if (bad_n) begin
              state <= S_RESP;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state   <= S_REQ;
              mem_req <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt && we_q) begin
            mem_req <= 1'b0;
            state   <= S_RESP;
            done    <= 1'b1;
          end else if (hit) begin
            mem_req   <= 1'b0;
            state     <= S_RESP;
            done      <= 1'b1;
            err       <= 1'b1;
            ld_data_f <= 32'h0;
          end else begin
            cnt <= cnt + CW'(1);
            if (mem_gnt) begin
              mem_req <= 1'b0;
              state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            ld_data_f <= fmt;
            state     <= S_RESP;
            done      <= 1'b1;
          end else if (hit) begin
            state     <= S_RESP;
            done      <= 1'b1;
            err       <= 1'b1;
            ld_data_f <= 32'h0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RESP: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level model and per-cycle compare.
// Honours LSU_MISALIGN_CHECK_EN the same way as the design.
module tb_load_store_unit;

  localparam int T = 16;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] ld_data_f;
  logic        done;
  logic        err;
  logic        busy;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .ld_data_f  (ld_data_f),
    .done       (done),
    .err        (err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        e_ready, e_busy, e_mreq, e_done, e_err, e_we;
  logic        e_mem_chk;
  logic [31:0] e_ld, e_addr, e_wdata;
  logic [3:0]  e_strb;
  bit          chk_en = 1'b0;
  int          cur_k, done_k, mreq_cnt;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  function automatic bit m_bad(input logic we, input logic [2:0] f3,
                               input int off);
    bit b;
    if (we) b = (f3 >= 3);
    else    b = (f3 == 3 || f3 == 6 || f3 == 7);
`ifdef LSU_MISALIGN_CHECK_EN
    if (f3[1:0] == 2'b01 && (off % 2) != 0) b = 1'b1;
    if (f3[1:0] == 2'b10 && off != 0) b = 1'b1;
`endif
    return b;
  endfunction

  function automatic int m_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input int off);
    int n;
    n = m_bytes(f3);
    if (n == 4) return 4'hF;
    return 4'((((1 << n) - 1) << off) & 15);
  endfunction

  function automatic logic [31:0] m_wlanes(input logic [2:0] f3, input int off,
                                           input logic [31:0] w);
    int n;
    n = m_bytes(f3);
    if (n == 1) return (w & 32'hFF) << (8 * off);
    if (n == 2) return (w & 32'hFFFF) << (8 * off);
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input int off,
                                         input logic [31:0] rd);
    int unsigned s, b, h;
    int v;
    s = rd >> (8 * off);
    b = s % 256;
    h = s % 65536;
    case (f3)
      3'd0: begin v = (b >= 128) ? int'(b) - 256 : int'(b); return 32'(v); end
      3'd1: begin v = (h >= 32768) ? int'(h) - 65536 : int'(h); return 32'(v); end
      3'd4: return 32'(b);
      3'd5: return 32'(h);
      default: return rd;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("mem_req", 32'(mem_req), 32'(e_mreq));
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(e_err));
      chk("ld_data_f", ld_data_f, e_ld);
      if (e_mem_chk) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(e_strb));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        if (e_we)
          chk("mem_wdata", mem_wdata & lane_mask(e_strb),
              e_wdata & lane_mask(e_strb));
      end
      if (done) done_k = cur_k;
      if (mem_req) mreq_cnt++;
    end
  end

  task automatic set_idle();
    e_ready = 1'b1; e_busy = 1'b0; e_mreq = 1'b0;
    e_done = 1'b0; e_err = 1'b0; e_mem_chk = 1'b0;
  endtask

  task automatic run_txn(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int gdly,
                         input int rdly, input bit stray);
    bit bd, tmo, in_req;
    int off, req_len, wait_len, resp_k;
    logic [31:0] nld;
    off = int'(addr[1:0]);
    bd = m_bad(we, f3, off);
    req_len = gdly + 1;
    wait_len = we ? 0 : rdly + 1;
    tmo = !bd && (req_len + wait_len > T);
    resp_k = tmo ? T + 1 : req_len + wait_len + 1;
    if (tmo) nld = 32'h0;
    else if (bd || we) nld = e_ld;
    else nld = m_load(f3, off, rdata);
    done_k = -1;
    mreq_cnt = 0;
    @(posedge clk); #1;
    cur_k = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; mem_rdata = rdata;
    set_idle();
    e_addr = {addr[31:2], 2'b00};
    e_strb = m_strb(f3, off);
    e_wdata = m_wlanes(f3, off, wdata);
    e_we = we;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cur_k = 1;
    e_ready = 1'b0; e_busy = 1'b1;
    if (bd) begin
      e_done = 1'b1; e_err = 1'b1;
    end else begin
      for (int k = 1; k < resp_k; k++) begin
        if (k > 1) begin @(posedge clk); #1; cur_k = k; end
        in_req = (k <= req_len);
        e_mreq = in_req;
        e_mem_chk = in_req;
        mem_gnt = in_req && (k == req_len);
        mem_rvalid = (!in_req && k == req_len + wait_len) || (stray && in_req);
      end
      @(posedge clk); #1;
      cur_k = resp_k;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      e_mreq = 1'b0; e_mem_chk = 1'b0;
      e_done = 1'b1; e_err = tmo; e_ld = nld;
    end
    @(posedge clk); #1;
    cur_k++;
    set_idle();
    mem_rvalid = stray;
    @(posedge clk); #1;
    cur_k++;
    mem_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_gnt = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    cur_k = 0; done_k = -1; mreq_cnt = 0;
    e_ld = 32'h0; e_addr = 32'h0; e_wdata = 32'h0; e_strb = 4'h0; e_we = 1'b0;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst mem_req", 32'(mem_req), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst ld_data_f", ld_data_f, 32'h0);
    chk("rst mem_wstrb", 32'(mem_wstrb), 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    run_txn(1'b0, 3'd0, 32'h0000_1003, 32'h0, 32'h80FF_FF00, 0, 0, 1'b0);
    chk("LB ld_data_f", ld_data_f, 32'hFFFF_FF80);
    chk("LB latency", 32'(done_k), 32'd3);

    run_txn(1'b1, 3'd1, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 0, 0, 1'b0);
    chk("SH latency", 32'(done_k), 32'd2);
    chk("SH model strb", 32'(e_strb), 32'hC);
    chk("SH model lanes", e_wdata, 32'hBEEF_0000);

    run_txn(1'b0, 3'd2, 32'h0000_4000, 32'h0, 32'h1234_5678, 3, 1, 1'b1);
    chk("LW mem_req cycles", 32'(mreq_cnt), 32'd4);
    chk("LW ld_data_f", ld_data_f, 32'h1234_5678);

    run_txn(1'b0, 3'd4, 32'h0000_5001, 32'h0, 32'h0000_A500, 1, 2, 1'b0);
    chk("LBU ld_data_f", ld_data_f, 32'h0000_00A5);
    run_txn(1'b0, 3'd1, 32'h0000_6002, 32'h0, 32'h8001_0000, 0, 0, 1'b0);
    chk("LH ld_data_f", ld_data_f, 32'hFFFF_8001);
    run_txn(1'b0, 3'd5, 32'h0000_6000, 32'h0, 32'h1234_F00F, 0, 0, 1'b0);
    chk("LHU ld_data_f", ld_data_f, 32'h0000_F00F);
    run_txn(1'b1, 3'd0, 32'h0000_7001, 32'h1234_56AB, 32'h0, 0, 0, 1'b0);
    run_txn(1'b1, 3'd2, 32'h0000_8000, 32'hDEAD_BEEF, 32'h0, 2, 0, 1'b0);

    run_txn(1'b0, 3'd3, 32'h0000_9000, 32'h0, 32'hFFFF_FFFF, 0, 0, 1'b0);
    chk("bad load keeps ld", ld_data_f, 32'h0000_F00F);
    chk("bad load latency", 32'(done_k), 32'd1);
    run_txn(1'b1, 3'd4, 32'h0000_9004, 32'h0, 32'h0, 0, 0, 1'b0);

    run_txn(1'b0, 3'd2, 32'h0000_A000, 32'h0, 32'h5555_5555, 100, 0, 1'b0);
    chk("timeout mem_req cycles", 32'(mreq_cnt), 32'd16);
    chk("timeout ld_data_f", ld_data_f, 32'h0);
    run_txn(1'b0, 3'd2, 32'h0000_A004, 32'h0, 32'h6666_6666, 15, 0, 1'b0);
    run_txn(1'b1, 3'd2, 32'h0000_A008, 32'h0BAD_F00D, 32'h0, 15, 0, 1'b0);
    chk("late gnt store latency", 32'(done_k), 32'd17);

    run_txn(1'b0, 3'd2, 32'h0000_0002, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("misalign LW ld_data_f", ld_data_f, 32'h0);
    chk("misalign LW mem_req", 32'(mreq_cnt), 32'd0);
`else
    chk("misalign LW ld_data_f", ld_data_f, 32'hCAFE_F00D);
    chk("misalign LW mem_req", 32'(mreq_cnt), 32'd1);
`endif

    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h3000;
    set_idle();
    @(posedge clk); #1;
    req_valid = 1'b0; mem_gnt = 1'b1;
    e_ready = 1'b0; e_busy = 1'b1; e_mreq = 1'b1; e_mem_chk = 1'b1;
    e_addr = 32'h3000; e_strb = 4'hF; e_we = 1'b0;
    @(posedge clk); #1;
    mem_gnt = 1'b0; e_mreq = 1'b0; e_mem_chk = 1'b0;
    #2;
    rst_n = 1'b0;
    set_idle();
    e_ld = 32'h0;
    #1;
    chk("rst mid mem_addr", mem_addr, 32'h0);
    chk("rst mid mem_wdata", mem_wdata, 32'h0);
    chk("rst mid busy", 32'(busy), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    @(posedge clk); #1;
    chk("post rst ld_data_f", ld_data_f, 32'h0);
    chk("post rst req_ready", 32'(req_ready), 32'h1);
    chk("post rst done", 32'(done), 32'h0);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
